// File: rtl/rf_wb_scoreboard.sv
// Register busy scoreboard with two-source (ALU/MEM) writeback arbiter; 1-cycle grant-to-write latency.
// Issue stalls combinationally on busy operands; MEM wins ties except after STARVE_MAX wins, then ALU is forced.
module rf_wb_scoreboard #(
    parameter int RF_NUM     = 32,
    parameter int GR_W       = 5,
    parameter int D_W        = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            iss_valid,
    input  logic [GR_W-1:0] iss_rj,
    input  logic [GR_W-1:0] iss_rk,
    input  logic [GR_W-1:0] iss_rd,
    input  logic            iss_wen,
    output logic            iss_ready,
    input  logic            alu_valid,
    input  logic [GR_W-1:0] alu_rd,
    input  logic [D_W-1:0]  alu_data,
    output logic            alu_ready,
    input  logic            mem_valid,
    input  logic [GR_W-1:0] mem_rd,
    input  logic [D_W-1:0]  mem_data,
    output logic            mem_ready,
    output logic            regWriteEn,
    output logic [GR_W-1:0] rd_in,
    output logic [D_W-1:0]  regWriteData,
    output logic [GR_W:0]   busy_cnt
);

    localparam logic [1:0] LP_STARVE_MAX = 2'(STARVE_MAX);

    logic [RF_NUM-1:0] r_busy;
    logic [RF_NUM-1:0] w_busy_nxt;
    logic [1:0]        r_starve;
    logic              w_starve_hit;
    logic              w_alu_gnt;
    logic              w_mem_gnt;
    logic              w_any_gnt;
    logic              w_iss_set;
    logic [GR_W-1:0]   w_wb_rd;
    logic [D_W-1:0]    w_wb_data;
    logic [GR_W:0]     w_busy_pop;

    // Hazard check looks only at registered busy bits: a same-cycle writeback does not unblock issue.
    assign iss_ready = iss_valid & ~flush & ~reset
                     & ~r_busy[iss_rj] & ~r_busy[iss_rk]
                     & ~(iss_wen & r_busy[iss_rd]);

    assign w_starve_hit = (r_starve == LP_STARVE_MAX);
    assign w_alu_gnt    = ~reset & alu_valid & (~mem_valid | w_starve_hit);
    assign w_mem_gnt    = ~reset & mem_valid & ~(alu_valid & w_starve_hit);
    assign w_any_gnt    = w_alu_gnt | w_mem_gnt;
    assign alu_ready    = w_alu_gnt;
    assign mem_ready    = w_mem_gnt;

    assign w_wb_rd   = w_alu_gnt ? alu_rd   : mem_rd;
    assign w_wb_data = w_alu_gnt ? alu_data : mem_data;
    assign w_iss_set = iss_ready & iss_wen & (iss_rd != '0);

    // Set is applied after the clear so a same-index set/clear leaves the bit busy.
    always_comb begin
        w_busy_nxt = flush ? '0 : r_busy;
        if (w_any_gnt) begin
            w_busy_nxt[w_wb_rd] = 1'b0;
        end
        if (w_iss_set) begin
            w_busy_nxt[iss_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_comb begin
        w_busy_pop = '0;
        for (int i = 0; i < RF_NUM; i++) begin
            w_busy_pop = w_busy_pop + (GR_W+1)'(w_busy_nxt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy       <= '0;
            r_starve     <= '0;
            regWriteEn   <= 1'b0;
            rd_in        <= '0;
            regWriteData <= '0;
            busy_cnt     <= '0;
        end else begin
            r_busy     <= w_busy_nxt;
            busy_cnt   <= w_busy_pop;
            regWriteEn <= w_any_gnt & (w_wb_rd != '0);
            if (w_any_gnt) begin
                rd_in        <= w_wb_rd;
                regWriteData <= w_wb_data;
            end
            if (flush || !alu_valid || w_alu_gnt) begin
                r_starve <= '0;
            end else if (w_mem_gnt) begin
                r_starve <= r_starve + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_scoreboard.sv
// Directed and randomized checks of the writeback scoreboard against a behavioural model.
module tb_rf_wb_scoreboard;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic        iss_valid, iss_wen;
    logic [4:0]  iss_rj, iss_rk, iss_rd;
    logic        iss_ready;
    logic        alu_valid, mem_valid;
    logic [4:0]  alu_rd, mem_rd;
    logic [31:0] alu_data, mem_data;
    logic        alu_ready, mem_ready;
    logic        regWriteEn;
    logic [4:0]  rd_in;
    logic [31:0] regWriteData;
    logic [5:0]  busy_cnt;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    bit [31:0]   m_busy;
    int          m_starve;
    bit          m_wen;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    bit          g_alu, g_mem;

    rf_wb_scoreboard dut (
        .clk(clk), .reset(reset), .flush(flush),
        .iss_valid(iss_valid), .iss_rj(iss_rj), .iss_rk(iss_rk), .iss_rd(iss_rd),
        .iss_wen(iss_wen), .iss_ready(iss_ready),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .regWriteEn(regWriteEn), .rd_in(rd_in), .regWriteData(regWriteData), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit exp_iss();
        return iss_valid && !flush && !reset && !m_busy[iss_rj] && !m_busy[iss_rk]
               && !(iss_wen && m_busy[iss_rd]);
    endfunction

    function automatic bit exp_alu_g();
        return !reset && alu_valid && (!mem_valid || m_starve == 3);
    endfunction

    function automatic bit exp_mem_g();
        return !reset && mem_valid && (!alu_valid || m_starve != 3);
    endfunction

    // Advance one clock: inputs are held across the posedge, model follows the rules, return at negedge.
    task automatic cyc();
        bit ga, gm, gi;
        ga = exp_alu_g();
        gm = exp_mem_g();
        gi = exp_iss();
        @(posedge clk);
        if (reset) begin
            m_busy = '0; m_starve = 0; m_wen = 0; m_rd = '0; m_data = '0;
        end else begin
            if (flush) m_busy = '0;
            if (ga) begin
                m_wen = (alu_rd != 0); m_rd = alu_rd; m_data = alu_data; m_busy[alu_rd] = 1'b0;
            end else if (gm) begin
                m_wen = (mem_rd != 0); m_rd = mem_rd; m_data = mem_data; m_busy[mem_rd] = 1'b0;
            end else begin
                m_wen = 0;
            end
            if (gi && iss_wen && iss_rd != 0) m_busy[iss_rd] = 1'b1;
            if (flush || !alu_valid || ga) m_starve = 0;
            else if (gm) m_starve = m_starve + 1;
        end
        g_alu = ga;
        g_mem = gm;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        flush = 0; iss_valid = 0; iss_wen = 0; iss_rj = 0; iss_rk = 0; iss_rd = 0;
        alu_valid = 0; alu_rd = 0; alu_data = 0; mem_valid = 0; mem_rd = 0; mem_data = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1; iss_valid = 1; alu_valid = 1; mem_valid = 1; alu_rd = 3; mem_rd = 4;
        #1;
        checks++; if (iss_ready !== 1'b0) begin failures++; $display("FAIL reset_iss_ready got=%b exp=0", iss_ready); end
        checks++; if ({alu_ready, mem_ready} !== 2'b00) begin failures++; $display("FAIL reset_grants got=%b exp=00", {alu_ready, mem_ready}); end
        cyc();
        cyc();
        checks++; if ({regWriteEn, rd_in, regWriteData, busy_cnt} !== '0) begin
            failures++; $display("FAIL reset_outputs got we=%b rd=%0d data=%h cnt=%0d exp all zero", regWriteEn, rd_in, regWriteData, busy_cnt);
        end
        reset = 0;
        idle_inputs();
        cyc();
    endtask

    task automatic test_issue_hazard();
        iss_valid = 1; iss_rd = 5; iss_wen = 1; iss_rj = 0; iss_rk = 0;
        #1;
        checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL haz_issue_rd5 got=%b exp=1", iss_ready); end
        cyc();
        checks++; if (busy_cnt !== 6'd1) begin failures++; $display("FAIL haz_busy_cnt got=%0d exp=1", busy_cnt); end
        iss_rj = 5; iss_rd = 6; iss_wen = 0;
        alu_valid = 1; alu_rd = 5; alu_data = 32'hA5A5A5A5;
        #1;
        checks++; if (iss_ready !== 1'b0) begin failures++; $display("FAIL haz_blocked got=%b exp=0", iss_ready); end
        checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL haz_alu_grant got=%b exp=1", alu_ready); end
        cyc();
        checks++; if ({regWriteEn, rd_in, regWriteData} !== {1'b1, 5'd5, 32'hA5A5A5A5}) begin
            failures++; $display("FAIL haz_writeback got we=%b rd=%0d data=%h exp we=1 rd=5 data=a5a5a5a5", regWriteEn, rd_in, regWriteData);
        end
        alu_valid = 0;
        #1;
        checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL haz_unblocked got=%b exp=1", iss_ready); end
        idle_inputs();
        cyc();
    endtask

    task automatic test_arbitration();
        string pat;
        logic [4:0] a_rd, m_rd_l, win_rd;
        pat = "MMMAMMMA";
        a_rd = 10; m_rd_l = 20;
        cyc();
        for (int i = 0; i < 8; i++) begin
            alu_valid = 1; alu_rd = a_rd; alu_data = 32'h1000 + 32'(i);
            mem_valid = 1; mem_rd = m_rd_l; mem_data = 32'h2000 + 32'(i);
            #1;
            checks++; if ({alu_ready, mem_ready} !== ((pat[i] == "A") ? 2'b10 : 2'b01)) begin
                failures++; $display("FAIL arb_grant_%0d got alu=%b mem=%b exp=%s", i, alu_ready, mem_ready, pat.substr(i, i));
            end
            win_rd = (pat[i] == "A") ? a_rd : m_rd_l;
            cyc();
            checks++; if ({regWriteEn, rd_in} !== {1'b1, win_rd}) begin
                failures++; $display("FAIL arb_write_%0d got we=%b rd=%0d exp we=1 rd=%0d", i, regWriteEn, rd_in, win_rd);
            end
            if (g_alu) a_rd = a_rd + 1;
            if (g_mem) m_rd_l = m_rd_l + 1;
        end
        idle_inputs();
        cyc();
    endtask

    task automatic test_rd_zero();
        logic [5:0] cnt0;
        cnt0 = busy_cnt;
        mem_valid = 1; mem_rd = 0; mem_data = 32'hFFFFFFFF;
        #1;
        checks++; if (mem_ready !== 1'b1) begin failures++; $display("FAIL rd0_grant got=%b exp=1", mem_ready); end
        cyc();
        checks++; if (regWriteEn !== 1'b0 || busy_cnt !== cnt0) begin
            failures++; $display("FAIL rd0_write got we=%b cnt=%0d exp we=0 cnt=%0d", regWriteEn, busy_cnt, cnt0);
        end
        idle_inputs();
    endtask

    task automatic test_flush();
        logic [4:0] regs [3];
        regs = '{5'd3, 5'd7, 5'd9};
        for (int i = 0; i < 3; i++) begin
            iss_valid = 1; iss_wen = 1; iss_rd = regs[i];
            cyc();
        end
        checks++; if (busy_cnt !== 6'd3) begin failures++; $display("FAIL flush_pre_cnt got=%0d exp=3", busy_cnt); end
        flush = 1; iss_valid = 1; iss_wen = 1; iss_rd = 12;
        alu_valid = 1; alu_rd = 7; alu_data = 32'h0BADF00D;
        #1;
        checks++; if (iss_ready !== 1'b0) begin failures++; $display("FAIL flush_iss_ready got=%b exp=0", iss_ready); end
        cyc();
        checks++; if ({busy_cnt, regWriteEn, rd_in} !== {6'd0, 1'b1, 5'd7}) begin
            failures++; $display("FAIL flush_result got cnt=%0d we=%b rd=%0d exp cnt=0 we=1 rd=7", busy_cnt, regWriteEn, rd_in);
        end
        idle_inputs();
    endtask

    task automatic test_flush_collide();
        iss_valid = 1; iss_wen = 1; iss_rd = 4;
        cyc();
        flush = 1; mem_valid = 1; mem_rd = 4; mem_data = 32'h44444444;
        #1;
        checks++; if ({iss_ready, mem_ready} !== 2'b01) begin
            failures++; $display("FAIL coll_ready got iss=%b mem=%b exp iss=0 mem=1", iss_ready, mem_ready);
        end
        cyc();
        checks++; if ({regWriteEn, rd_in, regWriteData, busy_cnt} !== {1'b1, 5'd4, 32'h44444444, 6'd0}) begin
            failures++; $display("FAIL coll_write got we=%b rd=%0d data=%h cnt=%0d exp we=1 rd=4 data=44444444 cnt=0", regWriteEn, rd_in, regWriteData, busy_cnt);
        end
        idle_inputs();
        iss_valid = 1; iss_rj = 4; iss_rd = 4; iss_wen = 1;
        #1;
        checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL coll_r4_free got=%b exp=1", iss_ready); end
        cyc();
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        flush = 1;
        cyc();
        flush = 0;
        for (int i = 1; i <= 6; i++) begin
            iss_valid = 1; iss_wen = 1; iss_rd = 5'(i);
            if (i == 6) begin alu_valid = 1; alu_rd = 20; alu_data = 32'h600DCAFE; end
            cyc();
        end
        checks++; if (busy_cnt !== 6'd6) begin failures++; $display("FAIL rmid_pre_cnt got=%0d exp=6", busy_cnt); end
        reset = 1; iss_valid = 1; iss_rd = 8;
        alu_valid = 1; alu_rd = 1; mem_valid = 1; mem_rd = 2;
        #1;
        checks++; if ({alu_ready, mem_ready, iss_ready} !== 3'b000) begin
            failures++; $display("FAIL rmid_ready got alu=%b mem=%b iss=%b exp 000", alu_ready, mem_ready, iss_ready);
        end
        cyc();
        checks++; if ({regWriteEn, rd_in, regWriteData, busy_cnt} !== '0) begin
            failures++; $display("FAIL rmid_outputs got we=%b rd=%0d data=%h cnt=%0d exp all zero", regWriteEn, rd_in, regWriteData, busy_cnt);
        end
        reset = 0;
        idle_inputs();
        cyc();
    endtask

    task automatic test_random();
        for (int n = 0; n < 500; n++) begin
            reset     = ($urandom_range(0, 99) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            iss_valid = 1'($urandom_range(0, 1));
            iss_wen   = 1'($urandom_range(0, 1));
            iss_rj    = 5'($urandom_range(0, 7));
            iss_rk    = 5'($urandom_range(0, 7));
            iss_rd    = 5'($urandom_range(0, 7));
            if (!alu_valid && $urandom_range(0, 1) == 1) begin
                alu_valid = 1; alu_rd = 5'($urandom_range(0, 7)); alu_data = $urandom;
            end
            if (!mem_valid && $urandom_range(0, 1) == 1) begin
                mem_valid = 1; mem_rd = 5'($urandom_range(0, 7)); mem_data = $urandom;
            end
            #1;
            checks++; if ({iss_ready, alu_ready, mem_ready} !== {exp_iss(), exp_alu_g(), exp_mem_g()}) begin
                failures++; $display("FAIL rand_ready_%0d got iss=%b alu=%b mem=%b exp iss=%b alu=%b mem=%b",
                    n, iss_ready, alu_ready, mem_ready, exp_iss(), exp_alu_g(), exp_mem_g());
            end
            cyc();
            checks++; if ({regWriteEn, rd_in, regWriteData} !== {m_wen, m_rd, m_data}) begin
                failures++; $display("FAIL rand_write_%0d got we=%b rd=%0d data=%h exp we=%b rd=%0d data=%h",
                    n, regWriteEn, rd_in, regWriteData, m_wen, m_rd, m_data);
            end
            checks++; if (busy_cnt !== 6'($countones(m_busy))) begin
                failures++; $display("FAIL rand_busy_cnt_%0d got=%0d exp=%0d", n, busy_cnt, $countones(m_busy));
            end
            if (g_alu) alu_valid = 0;
            if (g_mem) mem_valid = 0;
        end
        reset = 0;
        idle_inputs();
        cyc();
    endtask

    initial begin
        m_busy = '0; m_starve = 0; m_wen = 0; m_rd = '0; m_data = '0;
        g_alu = 0; g_mem = 0;
        test_reset();
        test_issue_hazard();
        test_arbitration();
        test_rd_zero();
        test_flush();
        test_flush_collide();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
